// File: rtl/load_store_unit.sv
// Memory stage: turns ALU results into data-memory requests or pass-through values
// and produces one registered writeback record per accepted op.
module load_store_unit #(
  parameter int REGISTER_WIDTH = 32,
  parameter int STRB_WIDTH     = REGISTER_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_load,
  input  logic                      in_is_store,
  input  logic [2:0]                in_funct3,
  input  logic [REGISTER_WIDTH-1:0] in_alu_result,
  input  logic [REGISTER_WIDTH-1:0] in_store_data,
  input  logic [4:0]                in_rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [REGISTER_WIDTH-1:0] mem_addr,
  output logic [REGISTER_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0]     mem_wstrb,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [REGISTER_WIDTH-1:0] mem_rdata,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [4:0]                wb_rd,
  output logic [REGISTER_WIDTH-1:0] wb_data,
  output logic                      wb_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [REGISTER_WIDTH-1:0] r_addr;
  logic [2:0]                r_funct3;
  logic                      r_is_store;
  logic [REGISTER_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0]     r_wstrb;
  logic [4:0]                r_rd;

  logic                      r_wb_valid;
  logic                      r_wb_we;
  logic                      r_wb_fault;
  logic [4:0]                r_wb_rd;
  logic [REGISTER_WIDTH-1:0] r_wb_data;

  logic                      w_is_mem;
  logic                      w_fault;
  logic [REGISTER_WIDTH-1:0] w_req_wdata;
  logic [STRB_WIDTH-1:0]     w_req_wstrb;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [REGISTER_WIDTH-1:0] w_load_data;

  assign w_is_mem = in_is_load | in_is_store;

  // Illegal encodings and misalignment are only meaningful for memory ops.
  always_comb begin
    w_fault = 1'b0;
    if (in_is_load)
      w_fault = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
    else if (in_is_store)
      w_fault = in_funct3[2] || (in_funct3[1:0] == 2'b11);
    if (w_is_mem && (in_funct3[1:0] == 2'b01) && in_alu_result[0])
      w_fault = 1'b1;
    if (w_is_mem && (in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00))
      w_fault = 1'b1;
  end

  always_comb begin
    w_req_wdata = '0;
    w_req_wstrb = '0;
    if (in_is_store) begin
      case (in_funct3[1:0])
        2'b00: begin
          w_req_wdata = {4{in_store_data[7:0]}};
          w_req_wstrb = 4'b0001 << in_alu_result[1:0];
        end
        2'b01: begin
          w_req_wdata = {2{in_store_data[15:0]}};
          w_req_wstrb = 4'b0011 << in_alu_result[1:0];
        end
        default: begin
          w_req_wdata = in_store_data;
          w_req_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid && w_is_mem && !w_fault) w_next_state = S_REQ;
      S_REQ:  if (mem_gnt) w_next_state = r_is_store ? S_IDLE : S_WAIT;
      S_WAIT: if (mem_rvalid) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_addr  = {r_addr[REGISTER_WIDTH-1:2], 2'b00};
        mem_wdata = r_wdata;
        mem_wstrb = r_wstrb;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at acceptance so they stay stable until the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rd       <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_addr     <= in_alu_result;
      r_funct3   <= in_funct3;
      r_is_store <= in_is_store;
      r_wdata    <= w_req_wdata;
      r_wstrb    <= w_req_wstrb;
      r_rd       <= in_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_fault <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && w_fault) begin
            r_wb_valid <= 1'b1;
            r_wb_fault <= 1'b1;
            r_wb_rd    <= in_rd;
          end else if (in_valid && !w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wb_rd    <= in_rd;
            r_wb_data  <= in_alu_result;
          end
        end
        S_REQ: begin
          if (mem_gnt && r_is_store) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_we    = r_wb_we;
  assign wb_fault = r_wb_fault;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-level memory model predicts
// every writeback and memory request; a word/strobe memory device answers the DUT.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_store_data;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  load_store_unit #(.REGISTER_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        fault;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          isMem;
    int          due;
  } wb_rec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_rec_t;

  wb_rec_t     expQ[$];
  mem_rec_t    reqQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          evtCycle = 0;
  logic [7:0]  modelMem[0:63];
  logic [31:0] devMem[0:15];
  bit          holdRvalid = 0;
  bit          loadPending = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h cycle=%0d", name, actual, expected, cycle);
    end
  endtask

  // Reference model: byte-addressed memory, access size and sign rules from funct3.
  task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    wb_rec_t  r;
    mem_rec_t m;
    int       guard = 0;
    int       off = int'(alu[5:0]);
    int       size;
    int       base;
    bit       fault = 0;
    longint   v = 0;
    while (!in_ready) begin
      in_valid = 1'b0;
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    base = off & ~3;
    r.rd = rd; r.due = cycle + 1; r.isMem = 0; r.data = '0; r.we = 0; r.fault = 0;
    if (ld || st) begin
      if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) fault = 1;
      if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) fault = 1;
      if (off % size != 0) fault = 1;
      if (fault) r.fault = 1;
      else begin
        r.isMem = 1;
        m.addr = {alu[31:2], 2'b00};
        m.we = st;
        m.wdata = '0;
        m.wstrb = '0;
        if (st) begin
          for (int i = 0; i < 4; i++) begin
            m.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
            if (base + i >= off && base + i < off + size) m.wstrb[i] = 1'b1;
          end
          for (int k = 0; k < size; k++) modelMem[off + k] = sd[8*k +: 8];
        end else begin
          for (int k = 0; k < size; k++) v = v | (longint'(modelMem[off + k]) << (8 * k));
          if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
          r.we = 1;
          r.data = v[31:0];
        end
        reqQ.push_back(m);
      end
    end else begin
      r.we = 1;
      r.data = alu;
    end
    expQ.push_back(r);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_result = alu; in_store_data = sd; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'($urandom_range(0, 7)); in_alu_result = $urandom(); in_store_data = $urandom();
  endtask

  // Monitor: pops the scoreboard on every writeback pulse.
  initial begin : monitor
    wb_rec_t r;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (wb_valid) begin
        if (expQ.size() == 0) checkOutput("unexpected_wb", 32'(wb_valid), 32'd0);
        else begin
          r = expQ.pop_front();
          checkOutput("wb_timing", cycle, r.isMem ? evtCycle + 1 : r.due);
          checkOutput("wb_we", 32'(wb_we), 32'(r.we));
          checkOutput("wb_fault", 32'(wb_fault), 32'(r.fault));
          checkOutput("wb_rd", 32'(wb_rd), 32'(r.rd));
          if (r.we) checkOutput("wb_data", wb_data, r.data);
        end
      end else begin
        checkOutput("idle_flags", 32'({wb_we, wb_fault}), 32'd0);
      end
    end
  end

  // Memory device: random grant and response delays, stray rvalid pulses.
  initial begin : device
    mem_rec_t cur;
    mem_rec_t e;
    bit       active = 0;
    int       gntDelay = 0;
    int       rvDelay = 0;
    logic [31:0] pendData = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (reset) begin
        active = 0;
        continue;
      end
      if (loadPending && !holdRvalid) begin
        if (rvDelay > 0) rvDelay--;
        else begin
          mem_rvalid = 1'b1; mem_rdata = pendData; loadPending = 0; evtCycle = cycle;
        end
      end else if (!loadPending && $urandom_range(0, 9) == 0) begin
        mem_rvalid = 1'b1;
      end
      if (mem_req) begin
        if (!active) begin
          active = 1;
          cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.wstrb = mem_wstrb;
          gntDelay = $urandom_range(0, 3);
          if (reqQ.size() == 0) checkOutput("unexpected_req", 32'(mem_req), 32'd0);
          else begin
            e = reqQ.pop_front();
            checkOutput("req_we", 32'(mem_we), 32'(e.we));
            checkOutput("req_addr", mem_addr, e.addr);
            checkOutput("req_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
            if (e.we) checkOutput("req_wdata", mem_wdata, e.wdata);
          end
        end else begin
          checkOutput("req_stable_addr", mem_addr, cur.addr);
          checkOutput("req_stable_data", mem_wdata, cur.wdata);
          checkOutput("req_stable_ctl", 32'({mem_we, mem_wstrb}), 32'({cur.we, cur.wstrb}));
        end
        if (gntDelay > 0) gntDelay--;
        else begin
          mem_gnt = 1'b1;
          active = 0;
          if (cur.we) begin
            for (int i = 0; i < 4; i++)
              if (cur.wstrb[i]) devMem[cur.addr[5:2]][8*i +: 8] = cur.wdata[8*i +: 8];
            evtCycle = cycle;
          end else begin
            loadPending = 1;
            rvDelay = $urandom_range(0, 2);
            pendData = devMem[cur.addr[5:2]];
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] w, a;
    logic [2:0]  f3;
    bit          ld, st;
    int          kind, guard;
    reset = 1'b1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
    in_alu_result = '0; in_store_data = '0; in_rd = '0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      devMem[i] = w;
      for (int k = 0; k < 4; k++) modelMem[4*i + k] = w[8*k +: 8];
    end
    devMem[0] = 32'h8001_1234;
    modelMem[0] = 8'h34; modelMem[1] = 8'h12; modelMem[2] = 8'h01; modelMem[3] = 8'h80;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mem_req", 32'({mem_req, mem_we, mem_wstrb}), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_wb_flags", 32'({wb_valid, wb_we, wb_fault}), 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 3'b000, 32'h0000_002A, 32'd0, 5'd5);
    applyStimulus(0, 0, 3'b000, 32'h0000_0055, 32'd0, 5'd6);
    applyStimulus(1, 0, 3'b001, 32'h0000_2002, 32'd0, 5'd8);
    applyStimulus(1, 0, 3'b101, 32'h0000_2002, 32'd0, 5'd9);
    applyStimulus(1, 0, 3'b000, 32'h0000_2000, 32'd0, 5'd10);
    applyStimulus(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd0);
    applyStimulus(1, 0, 3'b010, 32'h0000_3002, 32'd0, 5'd11);
    applyStimulus(1, 0, 3'b011, 32'h0000_3000, 32'd0, 5'd12);
    applyStimulus(0, 1, 3'b001, 32'h0000_1001, 32'h1234_5678, 5'd13);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      ld = (kind >= 3 && kind < 7);
      st = (kind >= 7);
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 4) != 0) f3 = 3'($urandom_range(0, 2));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      applyStimulus(ld, st, f3, a, $urandom(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Abandon a load in WAIT by reset; its late response must not produce a writeback.
    holdRvalid = 1;
    applyStimulus(1, 0, 3'b010, 32'h0000_1008, 32'd0, 5'd7);
    guard = 0;
    while (!loadPending && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("load_granted", 32'(loadPending), 32'd1);
    @(negedge clk);
    checkOutput("wait_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_async_memreq", 32'(mem_req), 32'd0);
    checkOutput("rst_async_wb", 32'({wb_valid, wb_we, wb_fault}), 32'd0);
    checkOutput("rst_async_wbdata", wb_data, 32'd0);
    expQ.delete();
    reqQ.delete();
    @(negedge clk);
    reset = 1'b0;
    holdRvalid = 0;
    repeat (8) @(negedge clk);
    applyStimulus(0, 0, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd0);

    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
